// File: rtl/vec_mem_sequencer_if.sv
// Bus bundle between the M-stage pipeline, the data memory and vec_mem_sequencer.
// The slave view belongs to the sequencer. The master view belongs to the environment
// (pipeline request side plus memory read data).
interface vec_mem_sequencer_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 32
);
    // M-stage request
    logic                   memreqM;
    logic                   memwriteM;
    logic                   vectorM;
    logic [31:0]            addrM;
    logic [LANES*WIDTH-1:0] wdataM;

    // single-word data-memory port
    logic [31:0]            mem_addr;
    logic [WIDTH-1:0]       mem_wdata;
    logic                   mem_we;
    logic                   mem_re;
    logic [WIDTH-1:0]       mem_rdata;

    // pipeline control and vector load result
    logic                   stallM;
    logic [LANES*WIDTH-1:0] rdataM;
    logic                   rvalidM;

    modport master (
        output memreqM, memwriteM, vectorM, addrM, wdataM, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, stallM, rdataM, rvalidM
    );

    modport slave (
        input  memreqM, memwriteM, vectorM, addrM, wdataM, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, stallM, rdataM, rvalidM
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// MEM-stage sequencer. Scalar accesses pass straight through to the single-word
// data memory. A vector access is split into LANES word accesses while the pipeline
// is stalled. For vector loads, the returned words are gathered into one LANES*WIDTH
// result for the W stage.
module vec_mem_sequencer #(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    vec_mem_sequencer_if.slave   bus
);

    localparam int CW = (LANES > 2) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LANE_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LAST_RD = 2'd2
    } state_t;

    // Byte address of lane `lane` relative to a word-aligned base (wraps mod 2^32).
    function automatic logic [31:0] laneAddr(input logic [31:0] base, input logic [CW-1:0] lane);
        return base + {{(30-CW){1'b0}}, lane, 2'b00};
    endfunction

    state_t                 state_r;
    state_t                 nextState_s;
    logic [CW-1:0]          laneCnt_r;
    logic [CW-1:0]          prevLane_s;
    logic [31:0]            baseAddr_r;
    logic                   isStore_r;
    logic [WIDTH-1:0]       wdata_r   [LANES];
    logic [WIDTH-1:0]       laneBuf_r [LANES];
    logic [LANES*WIDTH-1:0] rdataHold_r;

    logic [31:0]            base_s;
    logic                   vecReq_s;
    logic [LANES*WIDTH-1:0] assembled_s;
    logic                   unusedAddrLsb_s;

    logic [31:0]            memAddr_s;
    logic [WIDTH-1:0]       memWdata_s;
    logic                   memWe_s;
    logic                   memRe_s;
    logic                   stall_s;
    logic [LANES*WIDTH-1:0] rdata_s;
    logic                   rvalid_s;

    assign base_s          = {bus.addrM[31:2], 2'b00};
    assign unusedAddrLsb_s = ^bus.addrM[1:0];
    assign vecReq_s        = bus.memreqM & bus.vectorM;
    assign prevLane_s      = laneCnt_r - LANE_ONE;

    // The top lane comes straight from memory in LAST_RD. Lower lanes come from the buffer.
    for (genvar g = 0; g < LANES - 1; g++) begin : g_asm
        assign assembled_s[g*WIDTH +: WIDTH] = laneBuf_r[g];
    end
    assign assembled_s[(LANES-1)*WIDTH +: WIDTH] = bus.mem_rdata;

    // Next-state and memory/pipeline outputs for the current state and inputs.
    always_comb begin
        nextState_s = state_r;
        memAddr_s   = 32'h0000_0000;
        memWdata_s  = '0;
        memWe_s     = 1'b0;
        memRe_s     = 1'b0;
        stall_s     = 1'b0;
        rdata_s     = rdataHold_r;
        rvalid_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.memreqM) begin
                    memAddr_s  = base_s;
                    memWdata_s = bus.wdataM[WIDTH-1:0];
                    memWe_s    = bus.memwriteM;
                    memRe_s    = ~bus.memwriteM;
                    if (bus.vectorM) begin
                        stall_s     = 1'b1;
                        nextState_s = ISSUE;
                    end else begin
                        stall_s     = 1'b0;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            ISSUE: begin
                memAddr_s  = laneAddr(baseAddr_r, laneCnt_r);
                memWdata_s = wdata_r[laneCnt_r];
                memWe_s    = isStore_r;
                memRe_s    = ~isStore_r;
                if (laneCnt_r == LAST_LANE) begin
                    if (isStore_r) begin
                        // The final store lane releases the pipeline in the same cycle.
                        stall_s     = 1'b0;
                        nextState_s = IDLE;
                    end else begin
                        // The last load word is still in flight, so stay stalled one more cycle.
                        stall_s     = 1'b1;
                        nextState_s = LAST_RD;
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            LAST_RD: begin
                rdata_s     = assembled_s;
                rvalid_s    = 1'b1;
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State, lane counter, captured request and load data storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            laneCnt_r   <= '0;
            baseAddr_r  <= 32'h0000_0000;
            isStore_r   <= 1'b0;
            rdataHold_r <= '0;
            for (int i = 0; i < LANES; i++) begin
                wdata_r[i]   <= '0;
                laneBuf_r[i] <= '0;
            end
        end else begin
            state_r <= nextState_s;
            case (state_r)
                IDLE: begin
                    if (vecReq_s) begin
                        // Snapshot the request so upstream changes during the stall are harmless.
                        baseAddr_r <= base_s;
                        isStore_r  <= bus.memwriteM;
                        laneCnt_r  <= LANE_ONE;
                        for (int i = 0; i < LANES; i++) begin
                            wdata_r[i] <= bus.wdataM[i*WIDTH +: WIDTH];
                        end
                    end
                end
                ISSUE: begin
                    laneCnt_r <= laneCnt_r + LANE_ONE;
                    if (!isStore_r) begin
                        laneBuf_r[prevLane_s] <= bus.mem_rdata;
                    end
                end
                LAST_RD: begin
                    rdataHold_r <= assembled_s;
                end
                default: begin
                    laneCnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = memAddr_s;
    assign bus.mem_wdata = memWdata_s;
    assign bus.mem_we    = memWe_s;
    assign bus.mem_re    = memRe_s;
    assign bus.stallM    = stall_s;
    assign bus.rdataM    = rdata_s;
    assign bus.rvalidM   = rvalid_s;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with LANES=4 and WIDTH=32.
// It uses a one-cycle-latency memory model that returns addr ^ 0xA5A5.
module tb_vec_mem_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   nAsserts = 0;
    int   nFails   = 0;

    vec_mem_sequencer_if #(.LANES(4), .WIDTH(32)) bus ();

    vec_mem_sequencer #(.LANES(4), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears one cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= bus.mem_addr ^ 32'h0000_A5A5;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chkCtl(input string tag, input logic we, input logic re,
                          input logic stall, input logic rvalid);
        chk({tag, ".we"},     128'(bus.mem_we),  128'(we));
        chk({tag, ".re"},     128'(bus.mem_re),  128'(re));
        chk({tag, ".stall"},  128'(bus.stallM),  128'(stall));
        chk({tag, ".rvalid"}, 128'(bus.rvalidM), 128'(rvalid));
    endtask

    initial begin
        reset         = 1'b1;
        bus.memreqM   = 1'b0;
        bus.memwriteM = 1'b0;
        bus.vectorM   = 1'b0;
        bus.addrM     = 32'h0;
        bus.wdataM    = 128'h0;
        bus.mem_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state, then five idle cycles
        settle();
        chk("rst.addr",  128'(bus.mem_addr), 128'h0);
        chk("rst.rdata", bus.rdataM,         128'h0);
        for (int i = 0; i < 5; i++) begin
            chkCtl("idle", 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            settle();
        end

        // Scalar store
        tick();
        bus.memreqM = 1'b1; bus.memwriteM = 1'b1; bus.vectorM = 1'b0;
        bus.addrM = 32'h0000_0103; bus.wdataM = {96'h0, 32'hDEAD_BEEF};
        settle();
        chk("sst.addr",  128'(bus.mem_addr),  128'h100);
        chk("sst.wdata", 128'(bus.mem_wdata), 128'hDEAD_BEEF);
        chkCtl("sst", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.memreqM = 1'b0;
        settle();
        chkCtl("sst.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Vector store; the inputs are disturbed from T1 onward
        tick();
        bus.memreqM = 1'b1; bus.memwriteM = 1'b1; bus.vectorM = 1'b1;
        bus.addrM = 32'h0000_0200; bus.wdataM = {32'h44, 32'h33, 32'h22, 32'h11};
        settle();
        chk("vst0.addr",  128'(bus.mem_addr),  128'h200);
        chk("vst0.wdata", 128'(bus.mem_wdata), 128'h11);
        chkCtl("vst0", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        bus.memwriteM = 1'b0; bus.vectorM = 1'b0;
        bus.addrM = 32'h0000_0900; bus.wdataM = {4{32'hFFFF_FFFF}};
        settle();
        chk("vst1.addr",  128'(bus.mem_addr),  128'h204);
        chk("vst1.wdata", 128'(bus.mem_wdata), 128'h22);
        chkCtl("vst1", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        settle();
        chk("vst2.addr",  128'(bus.mem_addr),  128'h208);
        chk("vst2.wdata", 128'(bus.mem_wdata), 128'h33);
        chkCtl("vst2", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        bus.memreqM = 1'b0;
        settle();
        chk("vst3.addr",  128'(bus.mem_addr),  128'h20C);
        chk("vst3.wdata", 128'(bus.mem_wdata), 128'h44);
        chkCtl("vst3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        chkCtl("vst.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Vector load with address wrap, then an immediate scalar load
        tick();
        bus.memreqM = 1'b1; bus.memwriteM = 1'b0; bus.vectorM = 1'b1;
        bus.addrM = 32'hFFFF_FFF8; bus.wdataM = 128'h0;
        settle();
        chk("vld0.addr", 128'(bus.mem_addr), 128'hFFFF_FFF8);
        chkCtl("vld0", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        bus.memreqM = 1'b0;
        settle();
        chk("vld1.addr", 128'(bus.mem_addr), 128'hFFFF_FFFC);
        chkCtl("vld1", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        settle();
        chk("vld2.addr", 128'(bus.mem_addr), 128'h0);
        chkCtl("vld2", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        settle();
        chk("vld3.addr", 128'(bus.mem_addr), 128'h4);
        chkCtl("vld3", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        bus.memreqM = 1'b1; bus.memwriteM = 1'b0; bus.vectorM = 1'b0;
        bus.addrM = 32'h0000_0040;
        settle();
        chkCtl("vld4", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("vld4.rdata", bus.rdataM,
            {32'h0000_A5A1, 32'h0000_A5A5, 32'hFFFF_5A59, 32'hFFFF_5A5D});
        tick();
        settle();
        chk("sld.addr", 128'(bus.mem_addr), 128'h40);
        chkCtl("sld", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sld.hold", bus.rdataM,
            {32'h0000_A5A1, 32'h0000_A5A5, 32'hFFFF_5A59, 32'hFFFF_5A5D});
        tick();
        bus.memreqM = 1'b0;
        settle();
        chkCtl("sld.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Vector store abandoned by reset at T2
        tick();
        bus.memreqM = 1'b1; bus.memwriteM = 1'b1; bus.vectorM = 1'b1;
        bus.addrM = 32'h0000_0300; bus.wdataM = {32'h4, 32'h3, 32'h2, 32'h1};
        settle();
        chk("rvs0.addr", 128'(bus.mem_addr), 128'h300);
        chkCtl("rvs0", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        bus.memreqM = 1'b0;
        settle();
        chk("rvs1.addr", 128'(bus.mem_addr), 128'h304);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chkCtl("rvs3", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        chkCtl("rvs4", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- MEM-stage block directly downstream of the pipeline controller's M-stage outputs (memory write, memory-to-register, vector-register-write qualifiers).
- Drives the single-word data-memory port.
- Scalar accesses pass through in one cycle.
- Vector accesses are serialised into LANES word accesses. The block asserts stallM to freeze the pipeline and assembles vector load data for the W-stage register.

Parameters:
LANES, 4, elements per vector; power of two, >= 2
WIDTH, 32, element and memory word width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
memreqM  in  1  M-stage instruction accesses memory (load or store)
memwriteM  in  1  1 = store, 0 = load; qualified by memreqM
vectorM  in  1  1 = vector access of LANES elements, 0 = scalar
addrM  in  32  byte address from ALU result
wdataM  in  LANES*WIDTH  store data; scalar uses bits [WIDTH-1:0], lane i at [i*WIDTH +: WIDTH]
mem_addr  out  32  data-memory word address (byte address, bits [1:0] = 0)
mem_wdata  out  WIDTH  data-memory write data
mem_we  out  1  data-memory write enable
mem_re  out  1  data-memory read enable
mem_rdata  in  WIDTH  data-memory read data, valid exactly 1 cycle after mem_re
stallM  out  1  freeze F/D/E/M pipeline registers this cycle
rdataM  out  LANES*WIDTH  assembled vector load data
rvalidM  out  1  rdataM complete this cycle (single-cycle pulse)

Behaviour:
- Reset (sync, active-high): state=IDLE, lane counter=0, captured address, write data and lane buffer cleared to 0. While in IDLE with no request, all outputs are 0.
- Lane address: base = {addrM[31:2],2'b00}; lane i = base + 4*i, wrapping modulo 2^32. addrM[1:0] is ignored.
- FSM states are IDLE, ISSUE and LAST_RD.
- IDLE, scalar request (memreqM & ~vectorM):
  - Memory outputs are combinational from the inputs: mem_addr = base, mem_we = memwriteM, mem_re = ~memwriteM, mem_wdata = wdataM[WIDTH-1:0].
  - stallM = 0.
  - Scalar load data is taken by the W stage directly from mem_rdata; rvalidM stays 0.
- IDLE, vector request (memreqM & vectorM):
  - Lane 0 is issued combinationally in the same cycle.
  - base and wdataM are captured; lanes >= 1 use the captured copies.
  - stallM = 1, counter <= 1, next state = ISSUE.
- ISSUE: issue lane = counter from the captured values; counter increments each cycle.
  - Store: stallM = 1 except on the cycle issuing lane LANES-1, where stallM = 0; next state = IDLE.
  - Load: mem_rdata (lane counter-1) is written into the lane buffer. stallM = 1. After issuing lane LANES-1, next state = LAST_RD.
- LAST_RD: no memory access.
  - rdataM = lane buffer lanes 0..LANES-2 concatenated with mem_rdata in lane LANES-1 (combinational).
  - rvalidM = 1, stallM = 0, next state = IDLE.
- Latency:
  - Scalar access: 1 cycle, 0 stall cycles.
  - Vector store: LANES cycles, LANES-1 stall cycles.
  - Vector load: LANES+1 cycles, LANES stall cycles.
- Back-to-back: on the cycle stallM falls, the pipeline advances. The next cycle is IDLE and a new request is accepted immediately; there are no bubbles.
- Inputs are ignored outside IDLE. Captured copies make the block immune to upstream changes while stalled.
- mem_we and mem_re are never both 1. Neither is asserted in LAST_RD, or in IDLE without memreqM.
- Reset in any state: the next cycle is IDLE with stallM = 0. A partially issued vector store is abandoned; no further lanes are written.
- rdataM holds its last assembled value when rvalidM = 0. Consumers must qualify it with rvalidM.

Test Plan:
1. Reset, then hold memreqM = 0 for 5 cycles -> mem_we = mem_re = stallM = rvalidM = 0 every cycle.
2. Scalar store: addrM = 0x0000_0103, wdataM[31:0] = 0xDEADBEEF -> same cycle mem_addr = 0x100, mem_we = 1, mem_wdata = 0xDEADBEEF, stallM = 0; next cycle idle.
3. Vector store, LANES = 4, addrM = 0x200, lanes = 0x11, 0x22, 0x33, 0x44:
   - Cycles T0..T3 write 0x200/0x11, 0x204/0x22, 0x208/0x33, 0x20C/0x44.
   - stallM = 1,1,1,0.
   - Inputs changed at T1 have no effect.
4. Vector load, addrM = 0xFFFF_FFF8, memory model returns addr^0xA5A5 one cycle late:
   - Reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
   - stallM = 1 for T0..T3.
   - T4: rvalidM = 1, stallM = 0, rdataM lanes = model values in order.
5. Vector load immediately followed by a scalar load -> scalar issued at T5 with stallM = 0; rvalidM pulses only at T4.
6. Reset asserted at T2 of a vector store -> no write at T3; at T3 state is IDLE, stallM = 0, mem_we = 0.
